multi_one_shot: RTL and testbench

//  Multi-channel one-shot pulse generator for raw push-button or start inputs.
//  Per channel: synchronises the asynchronous input, debounces it, detects the

---
 rtl/multi_one_shot_pkg.sv | 21 ++
 rtl/multi_one_shot_channel.sv | 160 ++++++++++++++++
 rtl/multi_one_shot.sv | 40 ++++
 tb/tb_multi_one_shot.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/multi_one_shot_pkg.sv
// multi_one_shot_pkg: shared types, mode encodings and width helper
// for the multi-channel one-shot pulse generator.
package multi_one_shot_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } mos_state_t;

    localparam logic [1:0] MOS_RISE = 2'b00;
    localparam logic [1:0] MOS_FALL = 2'b01;
    localparam logic [1:0] MOS_BOTH = 2'b10;
    localparam logic [1:0] MOS_OFF  = 2'b11;

    // Width of a counter sized for value v: $clog2(max(v,2)).
    function automatic int unsigned cnt_w(input int unsigned v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/multi_one_shot_channel.sv
// one_shot_channel: synchroniser, debouncer and pulse FSM for one input.
// Ports: clk, reset (async low), i_start, i_mode, i_clear_missed -> o_shot, o_level, o_missed.
module one_shot_channel
    import multi_one_shot_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_WIDTH     = 1,
    parameter int unsigned REPEAT_DELAY    = 0,
    parameter int unsigned REPEAT_PERIOD   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_start,
    input  logic [1:0] i_mode,
    input  logic       i_clear_missed,
    output logic       o_shot,
    output logic       o_level,
    output logic       o_missed
);

    localparam int unsigned RPT_MAX =
        (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int DBW = cnt_w(DEBOUNCE_CYCLES);
    localparam int PWW = cnt_w(PULSE_WIDTH);
    localparam int RPW = cnt_w(RPT_MAX);

    localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PWW-1:0] PW_LAST = PWW'(PULSE_WIDTH - 1);
    localparam logic [RPW-1:0] RD_LAST =
        RPW'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [RPW-1:0] RP_LAST = RPW'(REPEAT_PERIOD - 1);

    logic           r_s1;
    logic           r_s2;
    logic [DBW-1:0] r_db;
    logic           r_level;
    logic           r_level_d;

    mos_state_t     r_state;
    logic           r_shot;
    logic           r_missed;
    logic [PWW-1:0] r_wcnt;
    logic [RPW-1:0] r_rep;
    logic           r_first;

    logic w_rise;
    logic w_fall;
    logic w_evt;
    logic w_hold_ok;
    logic w_rpt_hit;

    // Sync + debounce: counter runs only while the synced input disagrees
    // with the accepted level; it reaches DB_LAST after DEBOUNCE_CYCLES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_db      <= '0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
        end else begin
            r_s1      <= i_start;
            r_s2      <= r_s1;
            r_level_d <= r_level;
            if (r_s2 == r_level) begin
                r_db <= '0;
            end else if (r_db >= DB_LAST) begin
                r_level <= r_s2;
                r_db    <= '0;
            end else begin
                r_db <= r_db + 1'b1;
            end
        end
    end

    assign w_rise = r_level & ~r_level_d;
    assign w_fall = ~r_level & r_level_d;

    always_comb begin
        w_evt = 1'b0;
        unique case (i_mode)
            MOS_RISE: w_evt = w_rise;
            MOS_FALL: w_evt = w_fall;
            MOS_BOTH: w_evt = w_rise | w_fall;
            MOS_OFF:  w_evt = 1'b0;
        endcase
    end

    assign w_hold_ok = (REPEAT_DELAY != 0) && r_level &&
                       ((i_mode == MOS_RISE) || (i_mode == MOS_BOTH));

    // r_rep counts cycles since the current shot rose.
    assign w_rpt_hit = r_first ? (r_rep >= RD_LAST) : (r_rep >= RP_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_shot   <= 1'b0;
            r_missed <= 1'b0;
            r_wcnt   <= '0;
            r_rep    <= '0;
            r_first  <= 1'b0;
        end else begin
            if (r_rep != '1) begin
                r_rep <= r_rep + 1'b1;
            end
            // A miss in the same cycle as a clear keeps the flag set.
            if ((r_state == PULSE) && w_evt) begin
                r_missed <= 1'b1;
            end else if (i_clear_missed) begin
                r_missed <= 1'b0;
            end
            unique case (r_state)
                IDLE: begin
                    if (w_evt) begin
                        r_state <= PULSE;
                        r_shot  <= 1'b1;
                        r_wcnt  <= PW_LAST;
                        r_rep   <= '0;
                        r_first <= 1'b1;
                    end
                end
                PULSE: begin
                    if (r_wcnt == '0) begin
                        r_state <= w_hold_ok ? HOLD : IDLE;
                        r_shot  <= 1'b0;
                    end else begin
                        r_wcnt <= r_wcnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (w_evt) begin
                        r_state <= PULSE;
                        r_shot  <= 1'b1;
                        r_wcnt  <= PW_LAST;
                        r_rep   <= '0;
                        r_first <= 1'b1;
                    end else if (!w_hold_ok) begin
                        r_state <= IDLE;
                    end else if (w_rpt_hit) begin
                        r_state <= PULSE;
                        r_shot  <= 1'b1;
                        r_wcnt  <= PW_LAST;
                        r_rep   <= '0;
                        r_first <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_shot  <= 1'b0;
                end
            endcase
        end
    end

    assign o_shot   = r_shot;
    assign o_level  = r_level;
    assign o_missed = r_missed;

endmodule

// File: rtl/multi_one_shot.sv
// multi_one_shot: CHANNELS independent debounced one-shot generators.
// Ports: clk, reset (async low), start, mode, clear_missed -> shot, level, missed.
module multi_one_shot
    import multi_one_shot_pkg::*;
#(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PULSE_WIDTH     = 1,
    parameter int unsigned REPEAT_DELAY    = 0,
    parameter int unsigned REPEAT_PERIOD   = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] start,
    input  logic [1:0]          mode,
    input  logic                clear_missed,
    output logic [CHANNELS-1:0] shot,
    output logic [CHANNELS-1:0] level,
    output logic [CHANNELS-1:0] missed
);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        one_shot_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .PULSE_WIDTH     (PULSE_WIDTH),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk            (clk),
            .reset          (reset),
            .i_start        (start[g]),
            .i_mode         (mode),
            .i_clear_missed (clear_missed),
            .o_shot         (shot[g]),
            .o_level        (level[g]),
            .o_missed       (missed[g])
        );
    end

endmodule

// File: tb/tb_multi_one_shot.sv
// tb_multi_one_shot: directed checks of three multi_one_shot configurations
// (defaults, wide pulse with short debounce, auto-repeat).
module tb_multi_one_shot;
    import multi_one_shot_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] start;
    logic [1:0] mode;
    logic       clear_missed;

    logic [3:0] a_shot, a_level, a_missed;
    logic [3:0] b_shot, b_level, b_missed;
    logic [3:0] c_shot, c_level, c_missed;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    multi_one_shot u_a (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .clear_missed(clear_missed),
        .shot(a_shot), .level(a_level), .missed(a_missed)
    );

    multi_one_shot #(
        .CHANNELS(4), .DEBOUNCE_CYCLES(2), .PULSE_WIDTH(4)
    ) u_b (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .clear_missed(clear_missed),
        .shot(b_shot), .level(b_level), .missed(b_missed)
    );

    multi_one_shot #(
        .CHANNELS(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(5)
    ) u_c (
        .clk(clk), .reset(reset), .start(start), .mode(mode),
        .clear_missed(clear_missed),
        .shot(c_shot), .level(c_level), .missed(c_missed)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        repeat (n) cyc();
    endtask

    logic        exp_b;
    int          n;
    logic [2:0]  others;
    logic        acc;

    initial begin
        reset        = 1'b0;
        start        = '0;
        mode         = MOS_RISE;
        clear_missed = 1'b0;
        #12;
        chk("reset_outputs",
            {28'd0, a_shot, a_level, a_missed, b_shot, b_level, b_missed,
             c_shot, c_level, c_missed}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        settle(3);

        // 1: press, mode rise
        @(negedge clk);
        start[0] = 1'b1;
        for (int e = 0; e < 20; e++) begin
            cyc();
            chk($sformatf("t1_shot_e%0d", e), a_shot[0], e == 6);
        end
        chk("t1_level", a_level[0], 1'b1);
        @(negedge clk);
        start[0] = 1'b0;
        n = 0;
        for (int e = 0; e < 15; e++) begin
            cyc();
            n += a_shot[0];
        end
        chk("t1_release_noshot", n, 0);
        chk("t1_level_low", a_level[0], 1'b0);

        // 2: release mode
        @(negedge clk);
        mode     = MOS_FALL;
        start[0] = 1'b1;
        n        = 0;
        others   = '0;
        for (int e = 0; e < 20; e++) begin
            cyc();
            n      += a_shot[0];
            others |= a_shot[3:1];
        end
        chk("t2_press_noshot", n, 0);
        @(negedge clk);
        start[0] = 1'b0;
        for (int e = 0; e < 15; e++) begin
            cyc();
            chk($sformatf("t2_shot_e%0d", e), a_shot[0], e == 6);
            others |= a_shot[3:1];
        end
        chk("t2_other_ch", others, 3'd0);

        // 3: 3-cycle glitch is rejected
        @(negedge clk);
        mode     = MOS_RISE;
        start[1] = 1'b1;
        acc      = 1'b0;
        repeat (3) begin
            cyc();
            acc |= a_level[1] | a_shot[1];
        end
        @(negedge clk);
        start[1] = 1'b0;
        for (int e = 0; e < 15; e++) begin
            cyc();
            acc |= a_level[1] | a_shot[1];
        end
        chk("t3_glitch", acc, 1'b0);

        // 4: both edges, wide pulse, miss wins over clear
        @(negedge clk);
        mode       = MOS_BOTH;
        start[3:2] = 2'b11;
        for (int e = 0; e < 13; e++) begin
            cyc();
            exp_b = (e >= 4) && (e <= 7);
            chk($sformatf("t4_shot_e%0d", e), b_shot[2], exp_b);
            if (e == 1) begin
                @(negedge clk);
                start[3:2] = 2'b00;
            end
            if (e == 5) begin
                chk("t4_no_miss_yet", b_missed[3:2], 2'b00);
                @(negedge clk);
                clear_missed = 1'b1;
            end
            if (e == 6) begin
                clear_missed = 1'b0;
                chk("t4_miss_wins", b_missed[3:2], 2'b11);
            end
        end
        chk("t4_missed_sticky", b_missed[3:2], 2'b11);
        chk("t4_level_low", b_level[2], 1'b0);
        @(negedge clk);
        clear_missed = 1'b1;
        cyc();
        chk("t4_cleared", b_missed, 4'd0);
        clear_missed = 1'b0;

        // 5: hold-to-repeat
        @(negedge clk);
        mode = MOS_RISE;
        settle(15);
        @(negedge clk);
        start[0] = 1'b1;
        for (int e = 0; e < 56; e++) begin
            cyc();
            exp_b = (e == 6) ||
                    ((e >= 16) && (e <= 41) && ((e - 16) % 5 == 0));
            chk($sformatf("t5_shot_e%0d", e), c_shot[0], exp_b);
            if (e == 39) begin
                @(negedge clk);
                start[0] = 1'b0;
            end
        end

        // 6: async reset mid-pulse / mid-debounce
        settle(15);
        @(negedge clk);
        start[0] = 1'b1;
        settle(5);
        chk("t6_b_pulse_active", b_shot[0], 1'b1);
        chk("t6_a_mid_debounce", a_level[0], 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_async_reset",
            {28'd0, a_shot, a_level, a_missed, b_shot, b_level, b_missed,
             c_shot, c_level, c_missed}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int e = 0; e < 10; e++) begin
            cyc();
            chk($sformatf("t6_a_shot_e%0d", e), a_shot[0], e == 6);
            chk($sformatf("t6_a_level_e%0d", e), a_level[0], e >= 5);
            chk($sformatf("t6_b_shot_e%0d", e), b_shot[0],
                (e >= 4) && (e <= 7));
        end
        @(negedge clk);
        start = '0;
        settle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
